// File: rtl/keypad_scanner.sv
// Matrix-keypad scanner: walks one active-low column at a time, debounces over whole frames, rejects ghosting.
// Latency: key_valid one cycle after the close of the DEBOUNCE_SCANS-th agreeing frame.
// Backpressure: none; key_valid/key_release are single-cycle pulses, key_held/multi_key are levels.
// Ports: CLK/RST (async active-high), row (active-low, async to CLK), col (active-low drive),
//        key_code (row_idx*N_COLS+col_idx), key_valid, key_held, key_release, multi_key.
module keypad_scanner #(
  parameter int N_COLS         = 4,
  parameter int N_ROWS         = 4,
  parameter int SCAN_TICKS     = 100000,
  parameter int SETTLE         = 10,
  parameter int DEBOUNCE_SCANS = 3,
  localparam int KW = (N_ROWS * N_COLS > 1) ? $clog2(N_ROWS * N_COLS) : 1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [N_ROWS-1:0] row,
  output logic [N_COLS-1:0] col,
  output logic [KW-1:0]     key_code,
  output logic              key_valid,
  output logic              key_held,
  output logic              key_release,
  output logic              multi_key
);

  localparam int TW = $clog2(SCAN_TICKS);
  localparam int CW = $clog2(N_COLS);
  localparam int DW = $clog2(DEBOUNCE_SCANS + 1);

  typedef enum logic [1:0] {S_IDLE, S_DEBOUNCE, S_PRESSED, S_RELEASING} state_t;

  logic [TW-1:0]     r_scan_timer;
  logic [CW-1:0]     r_col_sel;
  logic [N_COLS-1:0] r_col;
  logic [N_ROWS-1:0] r_row_s1, r_row_s2;
  logic [1:0]        r_frame_cnt;   // saturates at 2: only 0/1/many matters
  logic [KW-1:0]     r_frame_code;
  state_t            r_state;
  logic [DW-1:0]     r_cnt;
  logic [KW-1:0]     r_cand;
  logic [KW-1:0]     r_key_code;
  logic              r_key_valid, r_key_held, r_key_release, r_multi_key;

  logic              w_timer_wrap;
  logic [CW-1:0]     w_sel_nxt;
  logic [N_COLS-1:0] w_col_nxt;
  logic              w_sample, w_close;
  logic [1:0]        w_samp_cnt;
  logic [KW-1:0]     w_samp_code;
  logic              w_samp_any;
  logic [2:0]        w_sum;
  logic [1:0]        w_tot;
  logic [KW-1:0]     w_code;
  logic              w_single, w_multi;
  logic [DW-1:0]     w_cnt_inc;
  state_t            w_state_nxt;
  logic [DW-1:0]     w_cnt_nxt;
  logic [KW-1:0]     w_cand_nxt, w_code_nxt;
  logic              w_valid_nxt, w_release_nxt, w_held_nxt;

  // Column walk; col is computed from the next select so it changes on the same edge.
  always_comb begin
    w_timer_wrap = (r_scan_timer == TW'(SCAN_TICKS - 1));
    w_sel_nxt    = r_col_sel;
    if (w_timer_wrap)
      w_sel_nxt = (r_col_sel == CW'(N_COLS - 1)) ? '0 : r_col_sel + CW'(1);
    w_col_nxt = '1;
    for (int c = 0; c < N_COLS; c++)
      if (int'(w_sel_nxt) == N_COLS - 1 - c) w_col_nxt[c] = 1'b0;
  end

  // Per-sample decode of the synchronised rows; the highest down row wins the code.
  always_comb begin
    w_samp_cnt  = '0;
    w_samp_code = '0;
    w_samp_any  = 1'b0;
    for (int r = 0; r < N_ROWS; r++) begin
      if (!r_row_s2[N_ROWS-1-r]) begin
        w_samp_any  = 1'b1;
        w_samp_code = KW'(r * N_COLS + int'(r_col_sel));
        if (w_samp_cnt != 2'd2) w_samp_cnt = w_samp_cnt + 2'd1;
      end
    end
    w_sum    = {1'b0, r_frame_cnt} + {1'b0, w_samp_cnt};
    w_tot    = (w_sum >= 3'd2) ? 2'd2 : w_sum[1:0];
    w_code   = w_samp_any ? w_samp_code : r_frame_code;
    w_sample = (r_scan_timer == TW'(SETTLE));
    w_close  = w_sample && (r_col_sel == CW'(N_COLS - 1));
    w_single = w_close && (w_tot == 2'd1);
    w_multi  = (w_tot == 2'd2);
  end

  // Debounce FSM, only advanced at frame close.
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_cand_nxt    = r_cand;
    w_code_nxt    = r_key_code;
    w_valid_nxt   = 1'b0;
    w_release_nxt = 1'b0;
    w_cnt_inc     = (r_cnt == DW'(DEBOUNCE_SCANS)) ? r_cnt : r_cnt + DW'(1);
    if (w_close) begin
      case (r_state)
        S_IDLE: begin
          if (w_single) begin
            if (DEBOUNCE_SCANS == 1) begin
              w_state_nxt = S_PRESSED;
              w_code_nxt  = w_code;
              w_valid_nxt = 1'b1;
            end else begin
              w_state_nxt = S_DEBOUNCE;
              w_cand_nxt  = w_code;
              w_cnt_nxt   = DW'(1);
            end
          end
        end
        S_DEBOUNCE: begin
          if (w_single && w_code == r_cand) begin
            w_cnt_nxt = w_cnt_inc;
            if (w_cnt_inc == DW'(DEBOUNCE_SCANS)) begin
              w_state_nxt = S_PRESSED;
              w_code_nxt  = r_cand;
              w_valid_nxt = 1'b1;
            end
          end else if (w_single) begin
            w_cand_nxt = w_code;
            w_cnt_nxt  = DW'(1);
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
        S_PRESSED: begin
          if (!(w_single && w_code == r_key_code)) begin
            if (DEBOUNCE_SCANS == 1) begin
              w_state_nxt   = S_IDLE;
              w_release_nxt = 1'b1;
            end else begin
              w_state_nxt = S_RELEASING;
              w_cnt_nxt   = DW'(1);
            end
          end
        end
        S_RELEASING: begin
          if (w_single && w_code == r_key_code) begin
            w_state_nxt = S_PRESSED;
          end else begin
            w_cnt_nxt = w_cnt_inc;
            if (w_cnt_inc == DW'(DEBOUNCE_SCANS)) begin
              w_state_nxt   = S_IDLE;
              w_release_nxt = 1'b1;
            end
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
    w_held_nxt = (w_state_nxt == S_PRESSED) || (w_state_nxt == S_RELEASING);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_scan_timer  <= '0;
      r_col_sel     <= '0;
      r_col         <= {1'b0, {(N_COLS-1){1'b1}}};
      r_row_s1      <= '1;
      r_row_s2      <= '1;
      r_frame_cnt   <= '0;
      r_frame_code  <= '0;
      r_state       <= S_IDLE;
      r_cnt         <= '0;
      r_cand        <= '0;
      r_key_code    <= '0;
      r_key_valid   <= 1'b0;
      r_key_held    <= 1'b0;
      r_key_release <= 1'b0;
      r_multi_key   <= 1'b0;
    end else begin
      r_scan_timer  <= w_timer_wrap ? '0 : r_scan_timer + TW'(1);
      r_col_sel     <= w_sel_nxt;
      r_col         <= w_col_nxt;
      r_row_s1      <= row;
      r_row_s2      <= r_row_s1;
      if (w_close) begin
        r_frame_cnt  <= '0;
        r_frame_code <= '0;
        r_multi_key  <= w_multi;
      end else if (w_sample) begin
        r_frame_cnt <= w_tot;
        if (w_samp_any) r_frame_code <= w_samp_code;
      end
      r_state       <= w_state_nxt;
      r_cnt         <= w_cnt_nxt;
      r_cand        <= w_cand_nxt;
      r_key_code    <= w_code_nxt;
      r_key_valid   <= w_valid_nxt;
      r_key_held    <= w_held_nxt;
      r_key_release <= w_release_nxt;
    end
  end

  assign col         = r_col;
  assign key_code    = r_key_code;
  assign key_valid   = r_key_valid;
  assign key_held    = r_key_held;
  assign key_release = r_key_release;
  assign multi_key   = r_multi_key;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with a 4x4 keypad model driven from the column outputs.
// Each frame is 4*20 = 80 cycles; stimulus is aligned to frame start where frame counting matters.
module tb_keypad_scanner;

  localparam int FR = 80;

  logic       CLK = 1'b0;
  logic       RST;
  logic [3:0] row;
  logic [3:0] col;
  logic [3:0] key_code;
  logic       key_valid, key_held, key_release, multi_key;

  logic [15:0] pressed;
  int vectors = 0;
  int errors  = 0;
  int n_valid, n_rel, n_both, n_held_hi, n_held_lo, n_multi_hi;
  logic [3:0] valid_code;

  keypad_scanner #(
    .N_COLS(4), .N_ROWS(4), .SCAN_TICKS(20), .SETTLE(5), .DEBOUNCE_SCANS(3)
  ) dut (
    .CLK(CLK), .RST(RST), .row(row), .col(col), .key_code(key_code),
    .key_valid(key_valid), .key_held(key_held), .key_release(key_release),
    .multi_key(multi_key)
  );

  always #5 CLK = ~CLK;

  // Keypad: key (r,c) pulls row[3-r] low while col[3-c] is driven low.
  always_comb begin
    row = 4'b1111;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r*4+c] && !col[3-c]) row[3-r] = 1'b0;
  end

  task automatic run_cycles(input int n);
    n_valid = 0; n_rel = 0; n_both = 0; n_held_hi = 0; n_held_lo = 0; n_multi_hi = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge CLK);
      if (key_valid) begin n_valid++; valid_code = key_code; end
      if (key_release) n_rel++;
      if (key_valid && key_release) n_both++;
      if (key_held) n_held_hi++; else n_held_lo++;
      if (multi_key) n_multi_hi++;
    end
  endtask

  // Returns at the negedge just after col switches to the first column (frame start).
  task automatic align;
    logic [3:0] prev;
    prev = col;
    for (int i = 0; i < 200; i++) begin
      @(negedge CLK);
      if (col == 4'b0111 && prev != 4'b0111) return;
      prev = col;
    end
    vectors++; errors++;
    $display("FAIL align: no frame start seen within 200 cycles, col=%b", col);
  endtask

  task automatic test_reset;
    RST = 1'b1; pressed = '0;
    #12;
    vectors++; if (col !== 4'b0111) begin errors++; $display("FAIL reset_col: got %b want 0111", col); end
    vectors++; if (key_code !== 4'd0) begin errors++; $display("FAIL reset_code: got %0d want 0", key_code); end
    vectors++; if ({key_valid, key_held, key_release, multi_key} !== 4'b0000) begin
      errors++; $display("FAIL reset_flags: got %b want 0000", {key_valid, key_held, key_release, multi_key}); end
    @(negedge CLK); RST = 1'b0;
  endtask

  task automatic test_free_run;
    logic [3:0] pat [4];
    int bad [5];
    int flags;
    pat[0] = 4'b0111; pat[1] = 4'b1011; pat[2] = 4'b1101; pat[3] = 4'b1110;
    for (int s = 0; s < 5; s++) bad[s] = 0;
    flags = 0;
    align();
    for (int i = 0; i < 100; i++) begin
      if (col !== pat[(i/20)%4]) bad[i/20]++;
      if (key_valid || key_held || key_release || multi_key) flags++;
      @(negedge CLK);
    end
    for (int s = 0; s < 5; s++) begin
      vectors++; if (bad[s] != 0) begin errors++;
        $display("FAIL free_run_slot%0d: %0d cycles off, want col=%b for 20 cycles", s, bad[s], pat[s%4]); end
    end
    vectors++; if (flags != 0) begin errors++; $display("FAIL free_run_flags: %0d flagged cycles, want 0", flags); end
  endtask

  task automatic test_short_press;
    align();
    pressed = 16'h0040;
    run_cycles(2*FR);
    pressed = '0;
    vectors++; if (n_held_hi != 0) begin errors++; $display("FAIL short_held: %0d held cycles want 0", n_held_hi); end
    run_cycles(3*FR);
    vectors++; if (n_valid != 0) begin errors++; $display("FAIL short_valid: %0d pulses want 0", n_valid); end
    vectors++; if (n_rel != 0 || n_held_hi != 0) begin errors++;
      $display("FAIL short_after: rel=%0d held=%0d want 0/0", n_rel, n_held_hi); end
  endtask

  task automatic test_press_accept;
    align();
    pressed = 16'h0040;
    run_cycles(2*FR);
    vectors++; if (n_valid != 0) begin errors++; $display("FAIL accept_early: %0d pulses in 2 frames want 0", n_valid); end
    run_cycles(3*FR);
    vectors++; if (n_valid != 1) begin errors++; $display("FAIL accept_count: %0d pulses want 1", n_valid); end
    vectors++; if (valid_code !== 4'd6) begin errors++; $display("FAIL accept_code: got %0d want 6", valid_code); end
    vectors++; if (key_held !== 1'b1 || key_code !== 4'd6) begin errors++;
      $display("FAIL accept_held: held=%b code=%0d want 1/6", key_held, key_code); end
  endtask

  task automatic test_release_bounce;
    align();
    pressed = '0;
    run_cycles(2*FR);
    vectors++; if (n_held_lo != 0 || n_rel != 0) begin errors++;
      $display("FAIL bounce_gap: held_lo=%0d rel=%0d want 0/0", n_held_lo, n_rel); end
    pressed = 16'h0040;
    run_cycles(2*FR);
    vectors++; if (n_valid != 0 || n_rel != 0 || n_held_lo != 0) begin errors++;
      $display("FAIL bounce_repress: valid=%0d rel=%0d held_lo=%0d want 0/0/0", n_valid, n_rel, n_held_lo); end
    pressed = '0;
    run_cycles(4*FR);
    vectors++; if (n_rel != 1 || n_valid != 0) begin errors++;
      $display("FAIL release_count: rel=%0d valid=%0d want 1/0", n_rel, n_valid); end
    vectors++; if (key_code !== 4'd6 || key_held !== 1'b0) begin errors++;
      $display("FAIL release_state: code=%0d held=%b want 6/0", key_code, key_held); end
  endtask

  task automatic test_multi_key;
    align();
    pressed = 16'h0042;
    run_cycles(3*FR);
    vectors++; if (multi_key !== 1'b1) begin errors++; $display("FAIL multi_flag: got %b want 1", multi_key); end
    vectors++; if (n_valid != 0 || n_held_hi != 0) begin errors++;
      $display("FAIL multi_valid: valid=%0d held=%0d want 0/0", n_valid, n_held_hi); end
    pressed = 16'h0040;
    run_cycles(2*FR);
    vectors++; if (multi_key !== 1'b0 || n_valid != 0) begin errors++;
      $display("FAIL multi_drop: multi=%b valid=%0d want 0/0", multi_key, n_valid); end
    run_cycles(FR);
    vectors++; if (n_valid != 1 || valid_code !== 4'd6) begin errors++;
      $display("FAIL multi_accept: valid=%0d code=%0d want 1/6", n_valid, valid_code); end
    pressed = '0;
    run_cycles(5*FR);
    vectors++; if (n_rel != 1 || n_both != 0) begin errors++;
      $display("FAIL multi_release: rel=%0d both=%0d want 1/0", n_rel, n_both); end
  endtask

  task automatic test_other_key;
    align();
    pressed = 16'h1000;  // row 3, column 0
    run_cycles(5*FR);
    vectors++; if (n_valid != 1 || valid_code !== 4'd12) begin errors++;
      $display("FAIL key12_accept: valid=%0d code=%0d want 1/12", n_valid, valid_code); end
    pressed = '0;
    run_cycles(5*FR);
    vectors++; if (n_rel != 1 || key_code !== 4'd12) begin errors++;
      $display("FAIL key12_release: rel=%0d code=%0d want 1/12", n_rel, key_code); end
  endtask

  task automatic test_reset_mid;
    align();
    pressed = 16'h0040;
    run_cycles(FR + 40);
    RST = 1'b1; #1;
    vectors++; if (col !== 4'b0111 || {key_valid, key_held, key_release, multi_key} !== 4'b0000) begin errors++;
      $display("FAIL rst_debounce: col=%b flags=%b want 0111/0000", col, {key_valid, key_held, key_release, multi_key}); end
    @(negedge CLK); RST = 1'b0; pressed = '0;
    run_cycles(3*FR);
    vectors++; if (n_valid != 0 || n_rel != 0) begin errors++;
      $display("FAIL rst_debounce_after: valid=%0d rel=%0d want 0/0", n_valid, n_rel); end
    align();
    pressed = 16'h0040;
    run_cycles(5*FR);
    vectors++; if (key_held !== 1'b1 || key_code !== 4'd6) begin errors++;
      $display("FAIL rst_pre_held: held=%b code=%0d want 1/6", key_held, key_code); end
    run_cycles(30);
    RST = 1'b1; #1;
    vectors++; if (col !== 4'b0111 || key_code !== 4'd0 || {key_valid, key_held, key_release, multi_key} !== 4'b0000) begin
      errors++; $display("FAIL rst_pressed: col=%b code=%0d flags=%b want 0111/0/0000",
        col, key_code, {key_valid, key_held, key_release, multi_key}); end
    @(negedge CLK); RST = 1'b0; pressed = '0;
    run_cycles(3*FR);
    vectors++; if (n_valid != 0 || n_rel != 0 || n_held_hi != 0) begin errors++;
      $display("FAIL rst_pressed_after: valid=%0d rel=%0d held=%0d want 0/0/0", n_valid, n_rel, n_held_hi); end
  endtask

  initial begin
    test_reset();
    test_free_run();
    test_short_press();
    test_press_accept();
    test_release_bounce();
    test_multi_key();
    test_other_key();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
